// File: rtl/text_write_scheduler.sv
// Shares the character-buffer write port between two requesters (round-robin)
// and a full-screen clear engine sized by the latched resolution select.
module text_write_scheduler #(
  parameter int         COLS_S     = 80,
  parameter int         ROWS_S     = 60,
  parameter int         COLS_L     = 40,
  parameter int         ROWS_L     = 30,
  parameter logic [6:0] CLR_ASCII  = 7'h20,
  parameter logic [5:0] CLR_COLOUR = 6'b111111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sL,
  input  logic       clear_req,
  input  logic       a_req,
  input  logic [6:0] a_x,
  input  logic [5:0] a_y,
  input  logic [6:0] a_ascii,
  input  logic [5:0] a_colour,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [6:0] b_x,
  input  logic [5:0] b_y,
  input  logic [6:0] b_ascii,
  input  logic [5:0] b_colour,
  output logic       b_ack,
  output logic [6:0] wrx,
  output logic [5:0] wry,
  output logic       wren,
  output logic [6:0] wascii,
  output logic [5:0] wcolour,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state;
  logic       clr_mode;
  logic       sweep_fin;
  logic       last_b;
  logic [6:0] cx;
  logic [5:0] cy;

  logic [6:0] last_x;
  logic [5:0] last_y;
  logic       a_elig;
  logic       b_elig;
  logic       grant_a;
  logic       grant_b;

  // A requester whose ack is already high is skipped so a held request is not written twice.
  always_comb begin
    last_x  = clr_mode ? 7'(COLS_L - 1) : 7'(COLS_S - 1);
    last_y  = clr_mode ? 6'(ROWS_L - 1) : 6'(ROWS_S - 1);
    a_elig  = a_req & ~a_ack;
    b_elig  = b_req & ~b_ack;
    grant_a = a_elig & (~b_elig | last_b);
    grant_b = b_elig & ~grant_a;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clr_mode  <= 1'b0;
      sweep_fin <= 1'b0;
      last_b    <= 1'b1;
      cx        <= '0;
      cy        <= '0;
      wrx       <= '0;
      wry       <= '0;
      wren      <= 1'b0;
      wascii    <= '0;
      wcolour   <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wren  <= 1'b0;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      done  <= 1'b0;
      if (state == IDLE && clear_req) begin
        clr_mode  <= sL;
        cx        <= '0;
        cy        <= '0;
        sweep_fin <= 1'b0;
        busy      <= 1'b1;
        state     <= CLEAR;
      end else if (state == CLEAR && !sweep_fin) begin
        wren    <= 1'b1;
        wrx     <= cx;
        wry     <= cy;
        wascii  <= CLR_ASCII;
        wcolour <= CLR_COLOUR;
        if (cx == last_x) begin
          cx <= '0;
          if (cy == last_y) sweep_fin <= 1'b1;
          else              cy <= cy + 6'd1;
        end else begin
          cx <= cx + 7'd1;
        end
      end else begin
        // Reached from IDLE without a clear request, or on the edge that closes a sweep.
        if (state == CLEAR) begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          sweep_fin <= 1'b0;
        end
        if (grant_a) begin
          wren    <= 1'b1;
          wrx     <= a_x;
          wry     <= a_y;
          wascii  <= a_ascii;
          wcolour <= a_colour;
          a_ack   <= 1'b1;
          last_b  <= 1'b0;
        end else if (grant_b) begin
          wren    <= 1'b1;
          wrx     <= b_x;
          wry     <= b_y;
          wascii  <= b_ascii;
          wcolour <= b_colour;
          b_ack   <= 1'b1;
          last_b  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_text_write_scheduler.sv
// Directed bench for text_write_scheduler: reset, arbitration, clear sweeps and
// requests arriving while a sweep is running.
module tb_text_write_scheduler;

  logic       clock;
  logic       reset;
  logic       sL;
  logic       clear_req;
  logic       a_req;
  logic [6:0] a_x;
  logic [5:0] a_y;
  logic [6:0] a_ascii;
  logic [5:0] a_colour;
  logic       a_ack;
  logic       b_req;
  logic [6:0] b_x;
  logic [5:0] b_y;
  logic [6:0] b_ascii;
  logic [5:0] b_colour;
  logic       b_ack;
  logic [6:0] wrx;
  logic [5:0] wry;
  logic       wren;
  logic [6:0] wascii;
  logic [5:0] wcolour;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  text_write_scheduler dut (
    .clock(clock), .reset(reset), .sL(sL), .clear_req(clear_req),
    .a_req(a_req), .a_x(a_x), .a_y(a_y), .a_ascii(a_ascii), .a_colour(a_colour), .a_ack(a_ack),
    .b_req(b_req), .b_x(b_x), .b_y(b_y), .b_ascii(b_ascii), .b_colour(b_colour), .b_ack(b_ack),
    .wrx(wrx), .wry(wry), .wren(wren), .wascii(wascii), .wcolour(wcolour),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_wren"},    32'(wren),    32'd0);
    check_output({tag, "_wrx"},     32'(wrx),     32'd0);
    check_output({tag, "_wry"},     32'(wry),     32'd0);
    check_output({tag, "_wascii"},  32'(wascii),  32'd0);
    check_output({tag, "_wcolour"}, 32'(wcolour), 32'd0);
    check_output({tag, "_acks"},    32'({a_ack, b_ack}), 32'd0);
    check_output({tag, "_busy"},    32'(busy),    32'd0);
    check_output({tag, "_done"},    32'(done),    32'd0);
  endtask

  // Pulses clear_req and follows the sweep to its done pulse, recording the cells seen.
  task automatic run_sweep(input logic mode, input int toggle_at, input int req_at,
                           output int writes, output int bad_data, output int early_ack,
                           output logic [12:0] xy80, output logic [12:0] xy81,
                           output logic [12:0] xy_last, output logic seen_done);
    writes    = 0;
    bad_data  = 0;
    early_ack = 0;
    xy80      = '0;
    xy81      = '0;
    xy_last   = '0;
    seen_done = 1'b0;
    @(negedge clock);
    sL        = mode;
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    check_output("clear_start_busy", 32'(busy), 32'd1);
    check_output("clear_start_wren", 32'(wren), 32'd0);
    for (int i = 0; i < 6000 && !seen_done; i++) begin
      @(negedge clock);
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (a_ack || b_ack) early_ack++;
        if (wren) begin
          writes++;
          if (wascii !== 7'h20 || wcolour !== 6'b111111) bad_data++;
          if (writes == 80) xy80 = {wrx, wry};
          if (writes == 81) xy81 = {wrx, wry};
          xy_last = {wrx, wry};
          if (writes == toggle_at) sL = ~sL;
          if (writes == req_at) a_req = 1'b1;
        end
      end
    end
  endtask

  int          writes;
  int          bad_data;
  int          early_ack;
  logic [12:0] xy80;
  logic [12:0] xy81;
  logic [12:0] xy_last;
  logic        seen_done;

  initial begin
    reset = 1'b1; sL = 1'b0; clear_req = 1'b0;
    a_req = 1'b0; a_x = '0; a_y = '0; a_ascii = '0; a_colour = '0;
    b_req = 1'b0; b_x = '0; b_y = '0; b_ascii = '0; b_colour = '0;
    #12;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // Reset in the middle of a sweep must clear everything without a clock edge.
    @(negedge clock);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    repeat (100) @(posedge clock);
    check_output("midclear_wren_before", 32'(wren), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("midclear_reset");
    @(negedge clock);
    reset = 1'b0;
    a_req = 1'b1; a_x = 7'd3; a_y = 6'd4; a_ascii = 7'h41; a_colour = 6'h15;
    @(negedge clock);
    check_output("a_write_wren",    32'(wren),    32'd1);
    check_output("a_write_wrx",     32'(wrx),     32'd3);
    check_output("a_write_wry",     32'(wry),     32'd4);
    check_output("a_write_wascii",  32'(wascii),  32'h41);
    check_output("a_write_wcolour", 32'(wcolour), 32'h15);
    check_output("a_write_ack",     32'({a_ack, b_ack}), 32'b10);
    a_req = 1'b0;
    @(negedge clock);
    check_output("a_write_after_wren", 32'(wren),  32'd0);
    check_output("a_write_after_ack",  32'(a_ack), 32'd0);

    // Fresh reset so the tie starts with A.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    a_req = 1'b1; a_x = 7'd10; a_y = 6'd11; a_ascii = 7'h61; a_colour = 6'h01;
    b_req = 1'b1; b_x = 7'd20; b_y = 6'd21; b_ascii = 7'h62; b_colour = 6'h02;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_output("tie_acks", 32'({a_ack, b_ack}), (i % 2 == 0) ? 32'b10 : 32'b01);
      check_output("tie_wrx",  32'(wrx), (i % 2 == 0) ? 32'd10 : 32'd20);
      check_output("tie_wren", 32'(wren), 32'd1);
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clock);
    check_output("tie_idle_wren", 32'(wren), 32'd0);
    check_output("tie_idle_wrx_hold", 32'(wrx), 32'd20);

    // A held request alone is granted every other cycle.
    a_req = 1'b1; a_x = 7'd1; a_y = 6'd2; a_ascii = 7'h30; a_colour = 6'h07;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check_output("single_a_ack", 32'(a_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_output("single_wren",  32'(wren),  (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    a_req = 1'b0;
    @(negedge clock);

    // Full 80x60 sweep.
    run_sweep(1'b0, -1, -1, writes, bad_data, early_ack, xy80, xy81, xy_last, seen_done);
    check_output("s0_done_seen", 32'(seen_done), 32'd1);
    check_output("s0_writes",    32'(writes),    32'd4800);
    check_output("s0_bad_data",  32'(bad_data),  32'd0);
    check_output("s0_write80",   32'(xy80),      32'({7'd79, 6'd0}));
    check_output("s0_write81",   32'(xy81),      32'({7'd0, 6'd1}));
    check_output("s0_last",      32'(xy_last),   32'({7'd79, 6'd59}));
    check_output("s0_done_busy", 32'(busy),      32'd0);
    check_output("s0_done_wren", 32'(wren),      32'd0);
    @(negedge clock);
    check_output("s0_done_pulse", 32'(done), 32'd0);

    // 40x30 sweep with sL flipped part way through.
    run_sweep(1'b1, 50, -1, writes, bad_data, early_ack, xy80, xy81, xy_last, seen_done);
    check_output("s1_done_seen", 32'(seen_done), 32'd1);
    check_output("s1_writes",    32'(writes),    32'd1200);
    check_output("s1_bad_data",  32'(bad_data),  32'd0);
    check_output("s1_write80",   32'(xy80),      32'({7'd39, 6'd1}));
    check_output("s1_last",      32'(xy_last),   32'({7'd39, 6'd29}));
    check_output("s1_done_busy", 32'(busy),      32'd0);
    @(negedge clock);
    check_output("s1_done_pulse", 32'(done), 32'd0);

    // A request raised during a sweep waits for the done edge.
    sL = 1'b1;
    a_x = 7'd5; a_y = 6'd6; a_ascii = 7'h42; a_colour = 6'h2a;
    run_sweep(1'b1, -1, 10, writes, bad_data, early_ack, xy80, xy81, xy_last, seen_done);
    check_output("rq_done_seen",  32'(seen_done), 32'd1);
    check_output("rq_writes",     32'(writes),    32'd1200);
    check_output("rq_early_ack",  32'(early_ack), 32'd0);
    check_output("rq_last",       32'(xy_last),   32'({7'd39, 6'd29}));
    check_output("rq_done_ack",   32'(a_ack),     32'd1);
    check_output("rq_done_wren",  32'(wren),      32'd1);
    check_output("rq_done_wrxy",  32'({wrx, wry}), 32'({7'd5, 6'd6}));
    check_output("rq_done_ascii", 32'(wascii),    32'h42);
    check_output("rq_done_busy",  32'(busy),      32'd0);
    a_req = 1'b0;
    @(negedge clock);
    check_output("rq_after_ack",  32'(a_ack), 32'd0);
    check_output("rq_after_wren", 32'(wren),  32'd0);
    check_output("rq_after_done", 32'(done),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_write_scheduler.md
Name: text_write_scheduler

Overview:
- Sequences and shares the single character write port (wrx/wry/wren/wascii/wcolour) of the text/colour buffers between two mode requesters and an internal screen-clear engine.
- Sits between the display modes and the character memory controller.
- Provides round-robin arbitration with a req/ack handshake.
- Provides a full-screen clear sweep sized by the current resolution select (sL).

Parameters:
COLS_S, 80, columns in 80x60 mode (sL=0)
ROWS_S, 60, rows in 80x60 mode
COLS_L, 40, columns in 40x30 mode (sL=1)
ROWS_L, 30, rows in 40x30 mode
CLR_ASCII, 7'h20, character written by clear
CLR_COLOUR, 6'b111111, colour written by clear

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
sL  in  1  resolution select: 0 = 80x60, 1 = 40x30
clear_req  in  1  start clear sweep (level, sampled in IDLE)
a_req  in  1  requester A write request
a_x  in  7  A column
a_y  in  6  A row
a_ascii  in  7  A character
a_colour  in  6  A colour
a_ack  out  1  one-cycle grant/complete for A
b_req, b_x, b_y, b_ascii, b_colour  in  1/7/6/7/6  requester B, same as A
b_ack  out  1  one-cycle grant/complete for B
wrx  out  7  write column (registered)
wry  out  6  write row (registered)
wren  out  1  write enable (registered)
wascii  out  7  write character (registered)
wcolour  out  6  write colour (registered)
busy  out  1  high while a clear is in progress
done  out  1  one-cycle pulse when a clear completes

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - wrx, wry, wren, wascii, wcolour, a_ack, b_ack, busy, done are all 0.
  - Clear counters are 0.
  - Round-robin pointer = B, so A wins the first tie.
- States: IDLE, CLEAR. All outputs are registered.
- IDLE, each edge, in priority order:
  - clear_req=1: latch sL into clr_mode, zero the counters, go to CLEAR. busy=1 after this edge; wren=0 this cycle. Pending A/B requests wait.
  - Else, eligible requesters are those with req=1 and their ack currently 0. A requester whose ack is high is not re-granted that edge, so no duplicate writes.
  - One eligible: grant it.
  - Both eligible: grant the one not last granted, then update the pointer.
  - Grant: wrx/wry/wascii/wcolour are loaded from the winner, wren=1, winner ack=1. All of these are high for exactly one cycle.
  - Latency: req sampled at edge E → write and ack visible after E.
  - Requester holds req and data stable until it sees ack; it may present the next write the cycle after ack.
  - No grant: wren=0, both acks=0, data outputs hold their last values.
- A single requester is granted at most every other cycle. Both requesting alternate grants every cycle.
- Coordinates from A/B are forwarded unchanged, with no bounds check; downstream ignores out-of-bounds writes.
- CLEAR:
  - Each edge emits wren=1, wrx=cx, wry=cy, wascii=CLR_ASCII, wcolour=CLR_COLOUR.
  - cx increments 0..cols-1. On wrap, cx=0 and cy increments.
  - cols/rows come from clr_mode (COLS_S/ROWS_S or COLS_L/ROWS_L).
  - After the cell (cols-1, rows-1) is emitted, the next edge sets wren=0, busy=0, done=1 for one cycle and returns to IDLE. Arbitration may grant on that same edge.
  - Sweep length is 4800 writes (sL=0) or 1200 writes (sL=1), one per cycle, no gaps.
- Changes to sL during CLEAR are ignored (clr_mode is latched).
- clear_req during CLEAR is ignored. clear_req still high when returning to IDLE starts a new clear, so it should be a pulse.
- A/B acks stay 0 during CLEAR.
- Counter widths: cx 7 bits, cy 6 bits. Comparisons are against cols-1 and rows-1, never 2^n.

Test Plan:
- Reset mid-clear: assert reset after 100 sweep cycles → all outputs 0 immediately (async). After release, a_req alone with (3,4,'A'=7'h41,6'h15) → one cycle later wren=1, wrx=3, wry=4, wascii=7'h41, wcolour=6'h15, a_ack=1, then wren=0 the following cycle.
- Tie: a_req and b_req both high and held → grants alternate A,B,A,B on consecutive cycles. A is first after reset. Never two consecutive acks to the same requester.
- Single held request: a_req high 6 cycles with no B → a_ack pattern 1,0,1,0,1,0. wren matches a_ack.
- Clear at sL=0: 1-cycle clear_req → busy=1. Exactly 4800 wren cycles. First write (0,0), write 80 is (79,0), write 81 is (0,1), last is (79,59). All writes carry 7'h20 / 6'b111111. Then done=1 for one cycle and busy=0.
- Clear at sL=1 with sL toggled mid-sweep → exactly 1200 writes, last (39,29), done pulse.
- Requests during clear: a_req asserted at sweep cycle 10 and held → no a_ack until the done cycle. A is granted on the done edge; its write appears the cycle after the last clear write.
